// File: rtl/fp_mac_result_buffer.sv
// Result FIFO with credit tracking behind the non-stalling FP MAC pipe.
// Optional same-cycle bypass when empty is enabled by defining FP_RESBUF_BYPASS_EN.
module fp_mac_result_buffer #(
  parameter int DEPTH      = 4,
  parameter int FP_WIDTH   = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int STAT_WIDTH = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     alloc_i,
  output logic                     credit_avail_o,
  input  logic                     unit_valid_i,
  input  logic [FP_WIDTH-1:0]      unit_res_i,
  input  logic [TAG_WIDTH-1:0]     unit_tag_i,
  input  logic [STAT_WIDTH-1:0]    unit_status_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [FP_WIDTH-1:0]      res_o,
  output logic [TAG_WIDTH-1:0]     tag_o,
  output logic [STAT_WIDTH-1:0]    status_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = FP_WIDTH + TAG_WIDTH + STAT_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_used;
  logic          r_err;

  logic          w_empty;
  logic          w_full;
  logic          w_valid;
  logic          w_bypassPop;
  logic          w_pop;
  logic          w_popMem;
  logic          w_push;
  logic          w_overflow;
  logic          w_allocOk;
  logic          w_allocErr;
  logic [EW-1:0] w_unitEntry;
  logic [EW-1:0] w_out;

  assign w_unitEntry = {unit_res_i, unit_tag_i, unit_status_i};
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL);

`ifdef FP_RESBUF_BYPASS_EN
  // An empty buffer forwards the arriving result; if taken at once it is never stored.
  assign w_valid     = !w_empty || unit_valid_i;
  assign w_out       = w_empty ? w_unitEntry : r_mem[r_rdPtr];
  assign w_bypassPop = w_empty && unit_valid_i && res_ready_i;
`else
  assign w_valid     = !w_empty;
  assign w_out       = r_mem[r_rdPtr];
  assign w_bypassPop = 1'b0;
`endif

  assign w_pop      = w_valid && res_ready_i;
  assign w_popMem   = w_pop && !w_empty;
  assign w_push     = unit_valid_i && (!w_full || w_pop) && !w_bypassPop;
  assign w_overflow = unit_valid_i && w_full && !w_pop;
  assign w_allocOk  = alloc_i && credit_avail_o;
  assign w_allocErr = alloc_i && !credit_avail_o;

  assign credit_avail_o = (r_used < FULL);
  assign res_valid_o    = w_valid;
  assign {res_o, tag_o, status_o} = w_valid ? w_out : '0;
  assign count_o        = r_count;
  assign err_o          = r_err;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_unitEntry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_popMem) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (w_push && !w_popMem) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_popMem) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Credits return on every pop, including a bypassed result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_used <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_allocOk && !w_pop) begin
        r_used <= r_used + CW'(1);
      end else if (!w_allocOk && w_pop) begin
        r_used <= r_used - CW'(1);
      end
      if (w_overflow || w_allocErr) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_mac_result_buffer.sv
// Self-checking bench for fp_mac_result_buffer: queue-based reference model,
// per-cycle output compare, directed scenarios with literal expectations and a random soak.
module tb_fp_mac_result_buffer;

  localparam int DEPTH = 4;
  localparam int FW    = 32;
  localparam int TW    = 4;
  localparam int SW    = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          alloc_i = 1'b0;
  logic          credit_avail_o;
  logic          unit_valid_i = 1'b0;
  logic [FW-1:0] unit_res_i = '0;
  logic [TW-1:0] unit_tag_i = '0;
  logic [SW-1:0] unit_status_i = '0;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic [FW-1:0] res_o;
  logic [TW-1:0] tag_o;
  logic [SW-1:0] status_o;
  logic [2:0]    count_o;
  logic          err_o;

  fp_mac_result_buffer #(
    .DEPTH(DEPTH), .FP_WIDTH(FW), .TAG_WIDTH(TW), .STAT_WIDTH(SW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .alloc_i(alloc_i), .credit_avail_o(credit_avail_o),
    .unit_valid_i(unit_valid_i), .unit_res_i(unit_res_i), .unit_tag_i(unit_tag_i),
    .unit_status_i(unit_status_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .tag_o(tag_o), .status_o(status_o), .count_o(count_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [FW-1:0] res;
    logic [TW-1:0] tag;
    logic [SW-1:0] st;
  } entry_t;

  entry_t mq[$];
  int     mUsed = 0;
  bit     mErr = 1'b0;
  bit     checkEn = 1'b0;
  int     inflight = 0;
  int     checks = 0;
  int     errors = 0;
  bit     mEmpty, mValid, mPop, mPush, mAllocOk;

  function automatic bit modelValid();
`ifdef FP_RESBUF_BYPASS_EN
    return (mq.size() > 0) || unit_valid_i;
`else
    return mq.size() > 0;
`endif
  endfunction

  function automatic entry_t modelHead();
    if (mq.size() > 0) return mq[0];
`ifdef FP_RESBUF_BYPASS_EN
    if (unit_valid_i) return entry_t'({unit_res_i, unit_tag_i, unit_status_i});
`endif
    return '0;
  endfunction

  // Reference model: FIFO as a queue, credits as a plain integer.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      mUsed = 0;
      mErr  = 1'b0;
    end else begin
      mEmpty   = (mq.size() == 0);
      mValid   = modelValid();
      mPop     = mValid && res_ready_i;
      mPush    = unit_valid_i && (mq.size() < DEPTH || mPop) && !(mEmpty && mPop);
      mAllocOk = alloc_i && (mUsed < DEPTH);
      if (unit_valid_i && mq.size() == DEPTH && !mPop) mErr = 1'b1;
      if (alloc_i && !mAllocOk) mErr = 1'b1;
      if (mPop && !mEmpty) void'(mq.pop_front());
      if (mPush) mq.push_back(entry_t'({unit_res_i, unit_tag_i, unit_status_i}));
      mUsed = mUsed + (mAllocOk ? 1 : 0) - (mPop ? 1 : 0);
    end
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    entry_t e;
    e = modelHead();
    checkValue("valid",  32'(res_valid_o),    32'(modelValid()));
    checkValue("res",    res_o,               e.res);
    checkValue("tag",    32'(tag_o),          32'(e.tag));
    checkValue("status", 32'(status_o),       32'(e.st));
    checkValue("count",  32'(count_o),        32'(mq.size()));
    checkValue("credit", 32'(credit_avail_o), 32'(mUsed < DEPTH));
    checkValue("err",    32'(err_o),          32'(mErr));
  endtask

  always @(negedge clk_i) begin
    if (checkEn && rst_ni) checkOutput();
  end

  task automatic applyStimulus(input logic a, input logic uv, input logic [FW-1:0] r,
                               input logic [TW-1:0] t, input logic [SW-1:0] s, input logic rdy);
    alloc_i       = a;
    unit_valid_i  = uv;
    unit_res_i    = r;
    unit_tag_i    = t;
    unit_status_i = s;
    res_ready_i   = rdy;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic resetDut(input bit verify);
    applyStimulus(0, 0, '0, '0, '0, 0);
    rst_ni = 1'b0;
    #1;
    if (verify) begin
      checkValue("rstValid",  32'(res_valid_o),    0);
      checkValue("rstCredit", 32'(credit_avail_o), 1);
      checkValue("rstCount",  32'(count_o),        0);
      checkValue("rstErr",    32'(err_o),          0);
      checkValue("rstRes",    res_o,               0);
    end
    @(posedge clk_i);
    #1;
    rst_ni   = 1'b1;
    inflight = 0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int issued, nextTag, popped, cyc;
    bit a, aOk, uv, rdy;

    resetDut(1);
    checkEn = 1'b1;

    // Single op: alloc in cycle 0, result in cycle 2.
    applyStimulus(1, 0, '0, '0, '0, 1);
    checkValue("t1Credit0", 32'(credit_avail_o), 1);
    nextCycle();
    applyStimulus(0, 0, '0, '0, '0, 1);
    nextCycle();
    applyStimulus(0, 1, 32'h3F800000, 4'd3, 5'd0, 1);
`ifdef FP_RESBUF_BYPASS_EN
    checkValue("t1BypValid", 32'(res_valid_o), 1);
    checkValue("t1BypRes",   res_o,            32'h3F800000);
    checkValue("t1BypTag",   32'(tag_o),       3);
`endif
    nextCycle();
    applyStimulus(0, 0, '0, '0, '0, 1);
`ifndef FP_RESBUF_BYPASS_EN
    checkValue("t1Valid", 32'(res_valid_o), 1);
    checkValue("t1Res",   res_o,            32'h3F800000);
    checkValue("t1Tag",   32'(tag_o),       3);
`endif
    nextCycle();
    applyStimulus(0, 0, '0, '0, '0, 0);
    checkValue("t1Count",  32'(count_o),        0);
    checkValue("t1Credit", 32'(credit_avail_o), 1);
    checkValue("t1Empty",  32'(res_valid_o),    0);
    nextCycle();

    // Credit exhaustion and over-allocation.
    resetDut(0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, '0, '0, '0, 0);
      checkValue($sformatf("t2Credit%0d", i), 32'(credit_avail_o), 1);
      nextCycle();
    end
    applyStimulus(1, 0, '0, '0, '0, 0);
    checkValue("t2CreditOut", 32'(credit_avail_o), 0);
    checkValue("t2ErrBefore", 32'(err_o),          0);
    nextCycle();
    applyStimulus(0, 1, 32'h40000000, 4'd7, 5'd1, 0);
    checkValue("t2ErrSet", 32'(err_o), 1);
    nextCycle();
    applyStimulus(0, 0, '0, '0, '0, 1);
    checkValue("t2HeadTag", 32'(tag_o), 7);
    nextCycle();
    applyStimulus(0, 0, '0, '0, '0, 0);
    checkValue("t2CreditBack", 32'(credit_avail_o), 1);
    checkValue("t2ErrSticky",  32'(err_o),          1);
    nextCycle();

    // Three stored, fourth result arrives with a pop.
    resetDut(0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, '0, '0, '0, 0);
      nextCycle();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'(i + 100), 4'(i), 5'(i), 0);
      nextCycle();
    end
    applyStimulus(0, 1, 32'd103, 4'd3, 5'd3, 1);
    checkValue("t3CountPre", 32'(count_o), 3);
    checkValue("t3Head0",    32'(tag_o),   0);
    nextCycle();
    applyStimulus(0, 0, '0, '0, '0, 0);
    checkValue("t3CountPost", 32'(count_o), 3);
    checkValue("t3Err",       32'(err_o),   0);
    nextCycle();
    for (int i = 1; i < 4; i++) begin
      applyStimulus(0, 0, '0, '0, '0, 1);
      checkValue($sformatf("t3Tag%0d", i), 32'(tag_o), 32'(i));
      checkValue($sformatf("t3Res%0d", i), res_o,      32'(i + 100));
      nextCycle();
    end
    applyStimulus(0, 0, '0, '0, '0, 0);
    checkValue("t3Drained", 32'(count_o),        0);
    checkValue("t3Credit",  32'(credit_avail_o), 1);
    nextCycle();

    // Wrap-around: ten tagged results, random back-pressure.
    resetDut(0);
    issued = 0; nextTag = 0; popped = 0; cyc = 0;
    while (popped < 10 && cyc < 400) begin
      a   = (issued < 10) && (mUsed < DEPTH) && ($urandom_range(1) == 1);
      uv  = (inflight > 0) && ($urandom_range(1) == 1);
      rdy = ($urandom_range(1) == 1);
      applyStimulus(a, uv, $urandom, uv ? 4'(nextTag) : 4'd0, 5'($urandom), rdy);
      if (uv) begin nextTag++; inflight--; end
      if (a) begin issued++; inflight++; end
      if (modelValid() && rdy) begin
        checkValue($sformatf("t4Tag%0d", popped), 32'(tag_o), 32'(popped));
        popped++;
      end
      nextCycle();
      cyc++;
    end
    checkValue("t4AllOut", 32'(popped), 10);
    applyStimulus(0, 0, '0, '0, '0, 0);
    checkValue("t4Err", 32'(err_o), 0);
    nextCycle();

    // Overflow on a full buffer without a pop.
    resetDut(0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, '0, '0, '0, 0);
      nextCycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 32'(i + 200), 4'(i), 5'(i), 0);
      nextCycle();
    end
    applyStimulus(0, 1, 32'hDEADBEEF, 4'd9, 5'd9, 0);
    checkValue("t5Full",     32'(count_o), 4);
    checkValue("t5ErrClear", 32'(err_o),   0);
    nextCycle();
    applyStimulus(0, 0, '0, '0, '0, 0);
    checkValue("t5Err",   32'(err_o),   1);
    checkValue("t5Count", 32'(count_o), 4);
    checkValue("t5Head",  32'(tag_o),   0);
    checkValue("t5Res",   res_o,        200);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, '0, '0, '0, 1);
      checkValue($sformatf("t5Tag%0d", i), 32'(tag_o), 32'(i));
      nextCycle();
    end

    // Reset with two entries stored.
    resetDut(0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, '0, '0, '0, 0);
      nextCycle();
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 32'(i + 300), 4'(i + 5), 5'(i), 0);
      nextCycle();
    end
    applyStimulus(0, 0, '0, '0, '0, 0);
    checkValue("t6Stored", 32'(count_o), 2);
    resetDut(1);

    // Random soak against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      a   = (mUsed < DEPTH) ? ($urandom_range(2) != 0) : ($urandom_range(19) == 0);
      aOk = a && (mUsed < DEPTH);
      uv  = (inflight > 0) && ($urandom_range(1) == 1);
      rdy = ($urandom_range(3) != 0);
      applyStimulus(a, uv, $urandom, 4'($urandom), 5'($urandom), rdy);
      if (uv) inflight--;
      if (aOk) inflight++;
      nextCycle();
      if ($urandom_range(499) == 0) resetDut(0);
    end

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
